// File: rtl/rx_ltssm.sv
// Receive-side LTSSM monitor: counts consecutive qualifying ordered sets for the
// commanded state, runs that state's timeout and reports a one-cycle exit flag.
module rx_ltssm #(
  parameter int         DEVICETYPE = 0,
  parameter int         T2MS       = 250000,
  parameter int         T24MS      = 3000000,
  parameter int         T48MS      = 6000000,
  parameter logic [7:0] PAD        = 8'hF7
) (
  input  logic       Pclk,
  input  logic       Reset,
  input  logic [3:0] SetRXState,
  output logic       RXFinishFlag,
  output logic [3:0] RXExitTo,
  input  logic [7:0] ReadLinkNum,
  output logic [7:0] WriteLinkNum,
  output logic       WriteLinkNumFlag,
  input  logic       RxOSValid,
  input  logic [2:0] RxOSType,
  input  logic [7:0] RxLinkNum,
  input  logic [7:0] RxLaneNum,
  output logic [7:0] ConsecCount
);

  localparam int TMAX_A = (T24MS > T2MS) ? T24MS : T2MS;
  localparam int TMAX   = (T48MS > TMAX_A) ? T48MS : TMAX_A;
  localparam int TW     = $clog2(TMAX + 1);

  localparam logic [2:0] OS_TS1  = 3'b000;
  localparam logic [2:0] OS_TS2  = 3'b001;
  localparam logic [2:0] OS_IDLE = 3'b100;

  localparam logic [3:0] S_DQ   = 4'd0;
  localparam logic [3:0] S_PA   = 4'd2;
  localparam logic [3:0] S_PC   = 4'd3;
  localparam logic [3:0] S_LWS  = 4'd4;
  localparam logic [3:0] S_LWA  = 4'd5;
  localparam logic [3:0] S_LNW  = 4'd6;
  localparam logic [3:0] S_LNA  = 4'd7;
  localparam logic [3:0] S_CC   = 4'd8;
  localparam logic [3:0] S_CI   = 4'd9;
  localparam logic [3:0] S_L0   = 4'd10;
  localparam logic [3:0] S_RRL  = 4'd11;
  localparam logic [3:0] S_IDLE = 4'd15;

  logic [3:0]    state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          done_q, done_d;
  logic          flag_q, flag_d;
  logic [3:0]    exit_q, exit_d;
  logic [7:0]    wl_q, wl_d;
  logic          wlf_q, wlf_d;

  logic          state_chg;
  logic          is_ts1, is_ts2, is_idle, pad_pad, link_ok;
  logic          qual, timed, hit, tout;
  logic [7:0]    need, cnt_inc;
  logic [3:0]    succ_to;
  logic [TW-1:0] tlim;

  assign state_chg = (SetRXState != state_q);
  assign is_ts1    = (RxOSType == OS_TS1);
  assign is_ts2    = (RxOSType == OS_TS2);
  assign is_idle   = (RxOSType == OS_IDLE);
  assign pad_pad   = (RxLinkNum == PAD) && (RxLaneNum == PAD);
  assign link_ok   = (RxLinkNum == ReadLinkNum) && (RxLaneNum != PAD);

  // Per-state exit rules; states without exits still count any defined OS type.
  always_comb begin
    qual    = is_ts1 || is_ts2 || is_idle;
    need    = 8'd0;
    succ_to = S_DQ;
    timed   = 1'b0;
    tlim    = '0;
    case (state_q)
      S_PA:  begin qual = (is_ts1 || is_ts2) && pad_pad; need = 8'd8; succ_to = S_PC;
                   timed = 1'b1; tlim = TW'(T24MS); end
      S_PC:  begin qual = is_ts2 && pad_pad; need = 8'd8; succ_to = S_LWS;
                   timed = 1'b1; tlim = TW'(T48MS); end
      S_LWS: begin qual = is_ts1 && (RxLinkNum != PAD) &&
                          ((DEVICETYPE == 1) || (RxLinkNum == ReadLinkNum));
                   need = 8'd2; succ_to = S_LWA; timed = 1'b1; tlim = TW'(T24MS); end
      S_LWA: begin qual = is_ts1 && link_ok; need = 8'd2; succ_to = S_LNW;
                   timed = 1'b1; tlim = TW'(T2MS); end
      S_LNW: begin qual = is_ts1 && link_ok; need = 8'd2; succ_to = S_LNA;
                   timed = 1'b1; tlim = TW'(T2MS); end
      S_LNA: begin qual = is_ts2 && link_ok; need = 8'd2; succ_to = S_CC;
                   timed = 1'b1; tlim = TW'(T2MS); end
      S_CC:  begin qual = is_ts2 && link_ok; need = 8'd8; succ_to = S_CI;
                   timed = 1'b1; tlim = TW'(T2MS); end
      S_CI:  begin qual = is_idle; need = 8'd8; succ_to = S_L0;
                   timed = 1'b1; tlim = TW'(T2MS); end
      S_L0:  begin qual = is_ts1; need = 8'd2; succ_to = S_RRL; end
      default: ;
    endcase
  end

  always_comb begin
    state_d = SetRXState;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    done_d  = done_q;
    flag_d  = 1'b0;
    exit_d  = exit_q;
    wl_d    = wl_q;
    wlf_d   = 1'b0;
    cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    hit     = RxOSValid && qual && (need != 8'd0) && (cnt_inc >= need);
    tout    = timed && (timer_q == tlim - TW'(1));
    if (state_chg) begin
      cnt_d   = 8'd0;
      timer_d = '0;
      done_d  = 1'b0;
    end else begin
      if (RxOSValid) cnt_d = qual ? cnt_inc : 8'd0;
      if (timed && (timer_q != '1)) timer_d = timer_q + TW'(1);
      // Success takes priority over a timeout landing on the same edge.
      if (!done_q && (hit || tout)) begin
        flag_d = 1'b1;
        done_d = 1'b1;
        exit_d = hit ? succ_to : S_DQ;
        if (hit && (DEVICETYPE == 1) && (state_q == S_LWS)) begin
          wlf_d = 1'b1;
          wl_d  = RxLinkNum;
        end
      end
    end
  end

  always_ff @(posedge Pclk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      timer_q <= '0;
      done_q  <= 1'b0;
      flag_q  <= 1'b0;
      exit_q  <= 4'd0;
      wl_q    <= 8'd0;
      wlf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      done_q  <= done_d;
      flag_q  <= flag_d;
      exit_q  <= exit_d;
      wl_q    <= wl_d;
      wlf_q   <= wlf_d;
    end
  end

  assign RXFinishFlag     = flag_q;
  assign RXExitTo         = exit_q;
  assign WriteLinkNum     = wl_q;
  assign WriteLinkNumFlag = wlf_q;
  assign ConsecCount      = cnt_q;

endmodule

// File: tb/tb_rx_ltssm.sv
// Bench for rx_ltssm: a downstream and an upstream instance share stimulus and
// are compared every cycle against a table-driven model of the exit rules.
module tb_rx_ltssm;

  localparam logic [7:0] PAD = 8'hF7;
  localparam int T2 = 20, T24 = 60, T48 = 100;

  logic       Pclk = 1'b0;
  logic       Reset;
  logic [3:0] SetRXState;
  logic [7:0] ReadLinkNum;
  logic       RxOSValid;
  logic [2:0] RxOSType;
  logic [7:0] RxLinkNum, RxLaneNum;

  logic       fl [2];
  logic [3:0] ex [2];
  logic [7:0] wl [2];
  logic       wlf [2];
  logic [7:0] cc [2];

  int n_total = 0, n_bad = 0;

  rx_ltssm #(.DEVICETYPE(0), .T2MS(T2), .T24MS(T24), .T48MS(T48), .PAD(PAD)) u_dn (
    .Pclk(Pclk), .Reset(Reset), .SetRXState(SetRXState),
    .RXFinishFlag(fl[0]), .RXExitTo(ex[0]), .ReadLinkNum(ReadLinkNum),
    .WriteLinkNum(wl[0]), .WriteLinkNumFlag(wlf[0]), .RxOSValid(RxOSValid),
    .RxOSType(RxOSType), .RxLinkNum(RxLinkNum), .RxLaneNum(RxLaneNum),
    .ConsecCount(cc[0]));

  rx_ltssm #(.DEVICETYPE(1), .T2MS(T2), .T24MS(T24), .T48MS(T48), .PAD(PAD)) u_up (
    .Pclk(Pclk), .Reset(Reset), .SetRXState(SetRXState),
    .RXFinishFlag(fl[1]), .RXExitTo(ex[1]), .ReadLinkNum(ReadLinkNum),
    .WriteLinkNum(wl[1]), .WriteLinkNumFlag(wlf[1]), .RxOSValid(RxOSValid),
    .RxOSType(RxOSType), .RxLinkNum(RxLinkNum), .RxLaneNum(RxLaneNum),
    .ConsecCount(cc[1]));

  always #5 Pclk = ~Pclk;

  // Exit-rule tables indexed by state: count needed, success target, timeout length.
  int need_t [16] = '{0, 0, 8, 8, 2, 2, 2, 2, 8, 8, 2, 0, 0, 0, 0, 0};
  int succ_t [16] = '{0, 0, 3, 4, 5, 6, 7, 8, 9, 10, 11, 0, 0, 0, 0, 0};
  int tmo_t  [16] = '{0, 0, T24, T48, T24, T2, T2, T2, T2, T2, 0, 0, 0, 0, 0, 0};

  int m_state;
  int m_cnt [2], m_age [2], m_exit [2], m_wl [2];
  bit m_done [2], m_flag [2], m_wlf [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit qualifies(int st, int dev, logic [2:0] ty, logic [7:0] ln,
                                   logic [7:0] la, logic [7:0] rd);
    bit t1 = (ty == 3'b000);
    bit t2 = (ty == 3'b001);
    bit id = (ty == 3'b100);
    case (st)
      2:       return (t1 || t2) && ln == PAD && la == PAD;
      3:       return t2 && ln == PAD && la == PAD;
      4:       return t1 && ln != PAD && (dev == 1 || ln == rd);
      5, 6:    return t1 && ln == rd && la != PAD;
      7, 8:    return t2 && ln == rd && la != PAD;
      9:       return id;
      10:      return t1;
      default: return t1 || t2 || id;
    endcase
  endfunction

  task automatic model_reset();
    m_state = 15;
    for (int d = 0; d < 2; d++) begin
      m_cnt[d] = 0; m_age[d] = 0; m_exit[d] = 0; m_wl[d] = 0;
      m_done[d] = 0; m_flag[d] = 0; m_wlf[d] = 0;
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit q, hit, tout;
    int c;
    for (int d = 0; d < 2; d++) begin
      m_flag[d] = 0;
      m_wlf[d]  = 0;
      if (int'(SetRXState) != m_state) begin
        m_cnt[d] = 0; m_age[d] = 0; m_done[d] = 0;
      end else begin
        m_age[d]++;
        q    = qualifies(m_state, d, RxOSType, RxLinkNum, RxLaneNum, ReadLinkNum);
        c    = (m_cnt[d] < 255) ? m_cnt[d] + 1 : 255;
        hit  = RxOSValid && q && need_t[m_state] > 0 && c >= need_t[m_state];
        tout = tmo_t[m_state] > 0 && m_age[d] == tmo_t[m_state];
        if (RxOSValid) m_cnt[d] = q ? c : 0;
        if (!m_done[d] && (hit || tout)) begin
          m_flag[d] = 1;
          m_done[d] = 1;
          m_exit[d] = hit ? succ_t[m_state] : 0;
          if (hit && d == 1 && m_state == 4) begin
            m_wlf[d] = 1;
            m_wl[d]  = RxLinkNum;
          end
        end
      end
    end
    m_state = SetRXState;
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("d%0d_flag", d), fl[d], m_flag[d]);
      check_eq($sformatf("d%0d_exit", d), ex[d], m_exit[d]);
      check_eq($sformatf("d%0d_cnt", d), cc[d], m_cnt[d]);
      check_eq($sformatf("d%0d_wl", d), wl[d], m_wl[d]);
      check_eq($sformatf("d%0d_wlf", d), wlf[d], m_wlf[d]);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge Pclk);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic go(input logic [3:0] s);
    SetRXState = s;
    tick();
  endtask

  task automatic send_os(input logic [2:0] ty, input logic [7:0] ln, input logic [7:0] la);
    RxOSValid = 1'b1; RxOSType = ty; RxLinkNum = ln; RxLaneNum = la;
    tick();
    RxOSValid = 1'b0;
  endtask

  task automatic async_reset(input string tag);
    Reset = 1'b1;
    #1;
    model_reset();
    check_all();
    check_eq({tag, "_cnt0"}, cc[0], 0);
    check_eq({tag, "_flag0"}, fl[1], 0);
    #1;
    Reset = 1'b0;
  endtask

  initial begin
    int first_at, pulses, first_exit, age;
    Reset = 1'b1; SetRXState = 4'd15; ReadLinkNum = 8'h01;
    RxOSValid = 1'b0; RxOSType = 3'b000; RxLinkNum = 8'h00; RxLaneNum = 8'h00;
    repeat (2) @(posedge Pclk);
    #1;
    model_reset();
    check_all();
    Reset = 1'b0;

    // PollingActive: 7 TS1 + 1 TS2, all PAD/PAD, 3 idle cycles apart.
    go(4'd2);
    for (int j = 1; j <= 8; j++) begin
      send_os((j < 8) ? 3'b000 : 3'b001, PAD, PAD);
      if (j == 8) begin
        check_eq("pa_flag", fl[0], 1);
        check_eq("pa_exit", ex[0], 3);
      end
      idle(3);
    end

    // Same, with a bad link number at position 5 restarting the count.
    go(4'd0);
    go(4'd2);
    for (int j = 1; j <= 13; j++) begin
      send_os(3'b000, (j == 5) ? 8'h01 : PAD, PAD);
      if (j == 8)  check_eq("pa2_early", fl[0], 0);
      if (j == 13) check_eq("pa2_exit", ex[0], 3);
      idle(3);
    end

    // PollingConfigration timeout with no traffic.
    go(4'd3);
    first_at = 0; pulses = 0; first_exit = 99;
    for (int i = 1; i <= 120; i++) begin
      tick();
      if (fl[0]) begin
        pulses++;
        if (first_at == 0) begin first_at = i; first_exit = ex[0]; end
      end
    end
    check_eq("pc_to_at", first_at, T48);
    check_eq("pc_to_n", pulses, 1);
    check_eq("pc_to_exit", first_exit, 0);

    // ConfigrationLinkWidthStart: upstream learns link 0x05, downstream ignores it.
    ReadLinkNum = 8'h01;
    go(4'd4);
    send_os(3'b000, 8'h05, PAD);
    idle(1);
    send_os(3'b000, 8'h05, PAD);
    check_eq("up_flag", fl[1], 1);
    check_eq("up_wlf", wlf[1], 1);
    check_eq("up_wl", wl[1], 8'h05);
    check_eq("up_exit", ex[1], 5);
    check_eq("dn_noflag", fl[0], 0);
    idle(2);
    go(4'd5);
    go(4'd4);
    send_os(3'b000, 8'h02, PAD);
    send_os(3'b000, 8'h02, PAD);
    check_eq("dn_wrong", fl[0], 0);
    send_os(3'b000, 8'h01, PAD);
    send_os(3'b000, 8'h01, PAD);
    check_eq("dn_flag", fl[0], 1);
    check_eq("dn_exit", ex[0], 5);
    idle(2);

    // ConfigrationIdle: 8th IDLE lands on the timeout edge; success wins.
    go(4'd9);
    age = 0;
    for (int j = 0; j < 7; j++) begin
      send_os(3'b100, 8'h00, 8'h00); age++;
      idle(1); age++;
    end
    while (age < T2 - 1) begin tick(); age++; end
    send_os(3'b100, 8'h00, 8'h00);
    check_eq("ci_flag", fl[0], 1);
    check_eq("ci_exit", ex[0], 10);
    idle(30);

    // Mid-count state change, then reset asserted mid-state.
    go(4'd2);
    for (int j = 0; j < 5; j++) send_os(3'b000, PAD, PAD);
    check_eq("mid_cnt5", cc[0], 5);
    go(4'd3);
    check_eq("chg_cnt0", cc[0], 0);
    for (int j = 0; j < 5; j++) send_os(3'b001, PAD, PAD);
    check_eq("pre_rst_cnt", cc[1], 5);
    async_reset("rst_mid");
    idle(4);

    // Randomized traffic across all states, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        int s = $urandom_range(0, 14);
        SetRXState = (s == 14) ? 4'd15 : 4'(s);
      end
      if ($urandom_range(0, 199) == 0) ReadLinkNum = 8'($urandom_range(0, 3));
      RxOSValid = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 3))
        0: RxOSType = 3'b000;
        1: RxOSType = 3'b001;
        2: RxOSType = 3'b100;
        default: RxOSType = 3'($urandom_range(2, 7));
      endcase
      case ($urandom_range(0, 3))
        0: RxLinkNum = PAD;
        1: RxLinkNum = ReadLinkNum;
        2: RxLinkNum = 8'h05;
        default: RxLinkNum = 8'($urandom);
      endcase
      case ($urandom_range(0, 2))
        0: RxLaneNum = PAD;
        1: RxLaneNum = 8'h03;
        default: RxLaneNum = 8'($urandom);
      endcase
      tick();
      if ($urandom_range(0, 499) == 0) async_reset("rst_rnd");
    end
    RxOSValid = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
